// File: rtl/cpu_loader.sv
// cpu_loader: UART boot monitor that loads/dumps RAM and starts the cpu,
// handing RAM and UART to the cpu while it runs.
module cpu_loader #(
    parameter int addr_width = 9,
    parameter logic [23:0] TIMEOUT = 24'd12_000_000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            rx_byte,
    input  logic                  received,
    output logic [7:0]            tx_byte,
    output logic                  transmit,
    input  logic                  is_transmitting,
    output logic [addr_width-1:0] ram_raddr,
    output logic [addr_width-1:0] ram_waddr,
    output logic [7:0]            ram_wdata,
    output logic                  ram_we,
    input  logic [7:0]            ram_rdata,
    input  logic [addr_width-1:0] cpu_raddr,
    input  logic [addr_width-1:0] cpu_waddr,
    input  logic [7:0]            cpu_dwrite,
    input  logic                  cpu_write_en,
    input  logic [7:0]            cpu_tx_byte,
    input  logic                  cpu_transmit,
    output logic                  cpu_is_transmitting,
    output logic                  cpu_received,
    output logic [7:0]            cpu_rx_byte,
    output logic                  cpu_start,
    output logic [addr_width-1:0] cpu_startaddr,
    input  logic                  cpu_halted,
    output logic                  running
);
    typedef enum logic [3:0] {
        IDLE, ARG1, ARG2, ARG3, LOAD, DRD, DWAIT, DLAT, RUNSTART, RUN, TX, TXHOLD
    } state_t;
    state_t state, ret;
    logic [7:0] cmd, hi, sum, tx_data, ld_tx, ld_wdata;
    logic [8:0] cnt;
    logic [addr_width-1:0] addr, ld_raddr, ld_waddr;
    logic ld_transmit, ld_we, waiting;
    logic [23:0] tcnt;

    assign waiting = state inside {ARG1, ARG2, ARG3, LOAD};
    assign ram_raddr = running ? cpu_raddr : ld_raddr;
    assign ram_waddr = running ? cpu_waddr : ld_waddr;
    assign ram_wdata = running ? cpu_dwrite : ld_wdata;
    assign ram_we = running ? cpu_write_en : ld_we;
    assign tx_byte = running ? cpu_tx_byte : ld_tx;
    assign transmit = running ? cpu_transmit : ld_transmit;
    assign cpu_is_transmitting = running ? is_transmitting : 1'b1;
    assign cpu_received = running & received;
    assign cpu_rx_byte = rx_byte;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            ret <= IDLE;
            cmd <= 8'd0;
            hi <= 8'd0;
            sum <= 8'd0;
            tx_data <= 8'd0;
            ld_tx <= 8'd0;
            ld_wdata <= 8'd0;
            cnt <= 9'd0;
            addr <= '0;
            ld_raddr <= '0;
            ld_waddr <= '0;
            ld_transmit <= 1'b0;
            ld_we <= 1'b0;
            tcnt <= 24'd0;
            running <= 1'b0;
            cpu_start <= 1'b0;
            cpu_startaddr <= '0;
        end else begin
            ld_we <= 1'b0;
            ld_transmit <= 1'b0;
            cpu_start <= 1'b0;
            tcnt <= (waiting && !received) ? tcnt + 24'd1 : 24'd0;
            if (waiting && !received && tcnt == TIMEOUT) begin
                tx_data <= 8'h3F;
                ret <= IDLE;
                state <= TX;
            end else begin
                case (state)
                    IDLE: if (received) begin
                        cmd <= rx_byte;
                        tx_data <= 8'h3F;
                        ret <= IDLE;
                        state <= (rx_byte inside {8'h4C, 8'h44, 8'h52}) ? ARG1 : TX;
                    end
                    ARG1: if (received) begin
                        hi <= rx_byte;
                        state <= ARG2;
                    end
                    ARG2: if (received) begin
                        addr <= {hi[addr_width-9:0], rx_byte};
                        if (cmd == 8'h52) cpu_startaddr <= {hi[addr_width-9:0], rx_byte};
                        state <= (cmd == 8'h52) ? RUNSTART : ARG3;
                    end
                    ARG3: if (received) begin
                        cnt <= {rx_byte == 8'd0, rx_byte};
                        sum <= 8'd0;
                        state <= (cmd == 8'h4C) ? LOAD : DRD;
                    end
                    LOAD: if (received) begin
                        ld_we <= 1'b1;
                        ld_waddr <= addr;
                        ld_wdata <= rx_byte;
                        addr <= addr + addr_width'(1);
                        sum <= sum + rx_byte;
                        tx_data <= sum + rx_byte;
                        cnt <= cnt - 9'd1;
                        if (cnt == 9'd1) state <= TX;
                    end
                    DRD: begin
                        ld_raddr <= addr;
                        addr <= addr + addr_width'(1);
                        cnt <= cnt - 9'd1;
                        state <= DWAIT;
                    end
                    DWAIT: state <= DLAT;
                    DLAT: begin
                        tx_data <= ram_rdata;
                        ret <= (cnt == 9'd0) ? IDLE : DRD;
                        state <= TX;
                    end
                    RUNSTART: begin
                        running <= 1'b1;
                        cpu_start <= 1'b1;
                        state <= RUN;
                    end
                    // halted is ignored during the start pulse so a stale flag cannot end the run
                    RUN: if (!cpu_start && cpu_halted) begin
                        running <= 1'b0;
                        tx_data <= 8'h48;
                        ret <= IDLE;
                        state <= TX;
                    end
                    TX: if (!is_transmitting) begin
                        ld_tx <= tx_data;
                        ld_transmit <= 1'b1;
                        state <= TXHOLD;
                    end
                    TXHOLD: state <= ret;
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule
